// File: rtl/alu_arbiter.sv
// Two-requester front end for one shared combinational ALU: IDLE grants and latches, EXEC captures, RESP hands back.
// Define ALU_ARB_RR_EN for round-robin tie breaking; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_valid_i,
    input  logic [WIDTH-1:0] req0_a_i,
    input  logic [WIDTH-1:0] req0_b_i,
    input  logic [2:0]       req0_op_i,
    output logic             req0_ready_o,
    input  logic             req1_valid_i,
    input  logic [WIDTH-1:0] req1_a_i,
    input  logic [WIDTH-1:0] req1_b_i,
    input  logic [2:0]       req1_op_i,
    output logic             req1_ready_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_result_i,
    input  logic             alu_zero_i,
    output logic             resp_valid_o,
    output logic [WIDTH-1:0] resp_result_o,
    output logic             resp_zero_o,
    output logic             resp_id_o,
    input  logic             resp_ready_i
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [2:0]       r_op_code;
    logic             r_op_id;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_zero;
    logic             r_resp_id;
    logic             w_grant_id;
    logic             w_accept;
`ifdef ALU_ARB_RR_EN
    logic             r_last_grant;
`endif

    // Grant selection: which requester would win if the arbiter accepts this cycle.
    always_comb begin
        w_grant_id = 1'b0;
`ifdef ALU_ARB_RR_EN
        // On a tie, requester 1 wins only when requester 0 was granted last.
        w_grant_id = req1_valid_i & (~req0_valid_i | ~r_last_grant);
`else
        w_grant_id = req1_valid_i & ~req0_valid_i;
`endif
    end

    // Next-state and accept decode.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req0_valid_i || req1_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end else begin
                    w_next_state = IDLE;
                end
            end
            EXEC: begin
                w_next_state = RESP;
            end
            RESP: begin
                if (resp_ready_i) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RESP;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State, operand and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_op_a        <= {WIDTH{1'b0}};
            r_op_b        <= {WIDTH{1'b0}};
            r_op_code     <= 3'b000;
            r_op_id       <= 1'b0;
            r_resp_result <= {WIDTH{1'b0}};
            r_resp_zero   <= 1'b0;
            r_resp_id     <= 1'b0;
`ifdef ALU_ARB_RR_EN
            r_last_grant  <= 1'b1;
`endif
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_op_a    <= w_grant_id ? req1_a_i  : req0_a_i;
                r_op_b    <= w_grant_id ? req1_b_i  : req0_b_i;
                r_op_code <= w_grant_id ? req1_op_i : req0_op_i;
                r_op_id   <= w_grant_id;
`ifdef ALU_ARB_RR_EN
                r_last_grant <= w_grant_id;
`endif
            end
            if (r_state == EXEC) begin
                r_resp_result <= alu_result_i;
                r_resp_zero   <= alu_zero_i;
                r_resp_id     <= r_op_id;
            end
        end
    end

    assign req0_ready_o  = w_accept & ~rst_i & ~w_grant_id;
    assign req1_ready_o  = w_accept & ~rst_i & w_grant_id;
    assign alu_a_o       = r_op_a;
    assign alu_b_o       = r_op_b;
    assign alu_op_o      = r_op_code;
    assign resp_valid_o  = (r_state == RESP);
    assign resp_result_o = r_resp_result;
    assign resp_zero_o   = r_resp_zero;
    assign resp_id_o     = r_resp_id;

endmodule
